// File: rtl/uart_rx_paddle.sv
// uart_rx_paddle: 8N1 UART receiver with paddle command decode and link-loss hold timer.
// Define RX_PARITY_EN for 8E1 framing with an extra par_err output.
module uart_rx_paddle #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int HOLD_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_err,
`ifdef RX_PARITY_EN
  output logic       par_err,
`endif
  output logic       paddle_up,
  output logic       paddle_down
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam int HW  = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] FULL = CW'(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [HW-1:0] HMAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
`ifdef RX_PARITY_EN
    PARITY    = 3'd5,
`endif
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state;
  logic          s1;
  logic          s2;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [HW-1:0] hold;
  logic          expire;
  logic          legal;
  logic          bad_par;

`ifdef RX_PARITY_EN
  logic          perr;
  assign bad_par = perr;
`else
  assign bad_par = 1'b0;
`endif

  assign rxs    = s2;
  assign expire = (cnt == ONE);
  assign legal  = (shift[7:2] == 6'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      hold        <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      cmd_err     <= 1'b0;
      paddle_up   <= 1'b0;
      paddle_down <= 1'b0;
`ifdef RX_PARITY_EN
      par_err     <= 1'b0;
      perr        <= 1'b0;
`endif
    end else begin
      s1        <= RxD;
      s2        <= s1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= 1'b0;
`ifdef RX_PARITY_EN
      par_err   <= 1'b0;
`endif

      // Link-loss timer; a legal command below overrides both updates.
      if (hold != HMAX) begin
        hold <= hold + 1'b1;
        if (hold == HLAST) begin
          paddle_up   <= 1'b0;
          paddle_down <= 1'b0;
        end
      end

      unique case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF;
            state <= START;
          end
        end

        START: begin
          if (!expire) begin
            cnt <= cnt - ONE;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            state <= DATA;
            idx   <= '0;
            cnt   <= FULL;
          end
        end

        DATA: begin
          if (!expire) begin
            cnt <= cnt - ONE;
          end else begin
            shift[idx] <= rxs;
            cnt        <= FULL;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef RX_PARITY_EN
        PARITY: begin
          if (!expire) begin
            cnt <= cnt - ONE;
          end else begin
            perr  <= ^{shift, rxs};
            cnt   <= FULL;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (!expire) begin
            cnt <= cnt - ONE;
          end else if (!rxs) begin
            frame_err <= 1'b1;
            state     <= WAIT_HIGH;
          end else begin
            // Back in IDLE mid-stop-bit so a following start edge is caught.
            state <= IDLE;
`ifdef RX_PARITY_EN
            par_err <= perr;
`endif
            if (!bad_par) begin
              rx_valid <= 1'b1;
              rx_data  <= shift;
              if (legal) begin
                hold        <= '0;
                paddle_up   <= (shift[1:0] == 2'b01);
                paddle_down <= (shift[1:0] == 2'b10);
              end else begin
                cmd_err <= 1'b1;
              end
            end
          end
        end

        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
